// File: rtl/alu_pkg.sv
// Shared ALU control encoding and multicycle ALU state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } alu_state_e;

endpackage

// File: rtl/multicycle_alu_if.sv
// Issue/result bundle between the execute stage and the multicycle ALU.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       ctrl_i;
  logic             start_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             overflow_o;
  logic             valid_o;
  logic             busy_o;

  modport master (
    output src1_i, src2_i, ctrl_i, start_i,
    input  result_o, zero_o, overflow_o, valid_o, busy_o
  );

  modport slave (
    input  src1_i, src2_i, ctrl_i, start_i,
    output result_o, zero_o, overflow_o, valid_o, busy_o
  );
endinterface

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, LSB first.
// Only the low WIDTH bits of the product are kept.
module shift_add_mul #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic             run,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             done
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] addend;

  assign addend  = mplier_q[0] ? mcand_q : '0;
  // product is the accumulator after the current step, so the top can
  // register it on the same edge that retires the last bit.
  assign product = acc_q + addend;
  assign done    = run && (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
      cnt_q    <= '0;
    end else if (run) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= done ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle logic/arith ops plus an iterative MUL
// with busy/valid handshake.
//
// state   | meaning
// IDLE    | ready; accepts start, single-cycle ops retire next cycle
// MUL_RUN | multiplier iterating; busy high, start ignored
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  multicycle_alu_if.slave bus
);

  alu_state_e       state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             overflow_q;
  logic             valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             mul_load;
  logic             mul_run;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign a    = bus.src1_i;
  assign b    = bus.src2_i;
  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.ctrl_i)
      ALU_AND: alu_res = a & b;
      ALU_OR:  alu_res = a | b;
      ALU_NOR: alu_res = ~(a | b);
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      // Direct signed compare rather than the sign of diff, so overflow
      // of A-B cannot flip the answer.
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  assign mul_load = (state_q == IDLE) && bus.start_i && (bus.ctrl_i == ALU_MUL);
  assign mul_run  = (state_q == MUL_RUN);

  shift_add_mul #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (mul_load),
    .run     (mul_run),
    .a       (a),
    .b       (b),
    .product (mul_product),
    .done    (mul_done)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (bus.ctrl_i == ALU_MUL) begin
              state_q <= MUL_RUN;
              busy_q  <= 1'b1;
            end else begin
              result_q   <= alu_res;
              zero_q     <= (alu_res == '0);
              overflow_q <= alu_ovf;
              valid_q    <= 1'b1;
            end
          end
        end
        MUL_RUN: begin
          if (mul_done) begin
            state_q    <= IDLE;
            result_q   <= mul_product;
            zero_q     <= (mul_product == '0);
            overflow_q <= 1'b0;
            valid_q    <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.result_o   = result_q;
  assign bus.zero_o     = zero_q;
  assign bus.overflow_o = overflow_q;
  assign bus.valid_o    = valid_q;
  assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed plus randomized checks of multicycle_alu against an arithmetic reference model.
module tb_multicycle_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  multicycle_alu_if #(.WIDTH(W)) alu_bus ();

  multicycle_alu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (alu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: results from plain signed/unsigned 64-bit arithmetic.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic ov);
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    ov = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        s  = sa + sb;
        r  = s[W-1:0];
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s  = sa - sb;
        r  = s[W-1:0];
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: begin
        p = {32'd0, a} * {32'd0, b};
        r = p[W-1:0];
      end
      default: r = '0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [W-1:0] r, input logic z,
                          input logic ov, input logic v, input logic bz);
    chk({tag, ".result"},   alu_bus.result_o,   r);
    chk({tag, ".zero"},     alu_bus.zero_o,     z);
    chk({tag, ".overflow"}, alu_bus.overflow_o, ov);
    chk({tag, ".valid"},    alu_bus.valid_o,    v);
    chk({tag, ".busy"},     alu_bus.busy_o,     bz);
  endtask

  // Called at a negedge; issues a single-cycle op and checks it one cycle later.
  task automatic issue_check(input string tag, input logic [3:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic ov;
    model(op, a, b, r, ov);
    alu_bus.src1_i  = a;
    alu_bus.src2_i  = b;
    alu_bus.ctrl_i  = op;
    alu_bus.start_i = 1'b1;
    @(negedge clk);
    alu_bus.start_i = 1'b0;
    chk_outs(tag, r, (r == '0), ov, 1'b1, 1'b0);
  endtask

  // Called at a negedge; runs a full MUL, checking busy every cycle and the
  // result in cycle W+1. Operands are scrambled after acceptance; optional
  // ADD poke in cycle 10 must be ignored.
  task automatic mul_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit poke);
    logic [W-1:0] r;
    logic ov;
    model(ALU_MUL, a, b, r, ov);
    alu_bus.src1_i  = a;
    alu_bus.src2_i  = b;
    alu_bus.ctrl_i  = ALU_MUL;
    alu_bus.start_i = 1'b1;
    for (int cyc = 1; cyc <= W; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        alu_bus.start_i = 1'b0;
        alu_bus.src1_i  = $urandom;
        alu_bus.src2_i  = $urandom;
        alu_bus.ctrl_i  = ALU_AND;
      end
      if (poke && cyc == 10) begin
        alu_bus.start_i = 1'b1;
        alu_bus.ctrl_i  = ALU_ADD;
      end
      if (cyc == 11) alu_bus.start_i = 1'b0;
      chk({tag, ".busy_run"},  alu_bus.busy_o,  1'b1);
      chk({tag, ".valid_run"}, alu_bus.valid_o, 1'b0);
    end
    @(negedge clk);
    chk_outs({tag, ".done"}, r, (r == '0), 1'b0, 1'b1, 1'b0);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return W'($urandom_range(0, 15));
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] ops [8];
    logic [3:0] op;
    logic [W-1:0] ra, rb;
    int pulses;

    ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_MUL, 4'b0101};
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    alu_bus.src1_i  = '0;
    alu_bus.src2_i  = '0;
    alu_bus.ctrl_i  = '0;
    alu_bus.start_i = 1'b0;

    #1;
    chk_outs("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue_check("add_7_5", ALU_ADD, 32'd7, 32'd5);
    chk("add_7_5.result_const", alu_bus.result_o, 32'd12);
    @(negedge clk);
    chk("add_7_5.valid_drop", alu_bus.valid_o, 1'b0);
    chk("add_7_5.hold", alu_bus.result_o, 32'd12);

    issue_check("sub_5_7", ALU_SUB, 32'd5, 32'd7);
    chk("sub_5_7.result_const", alu_bus.result_o, 32'hFFFF_FFFE);
    issue_check("slt_5_7", ALU_SLT, 32'd5, 32'd7);
    chk("slt_5_7.result_const", alu_bus.result_o, 32'd1);
    issue_check("slt_min_1", ALU_SLT, 32'h8000_0000, 32'd1);
    chk("slt_min_1.result_const", alu_bus.result_o, 32'd1);
    @(negedge clk);
    chk("slt.valid_drop", alu_bus.valid_o, 1'b0);

    issue_check("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    chk("add_ovf.ovf_const", alu_bus.overflow_o, 1'b1);
    issue_check("sub_ovf", ALU_SUB, 32'h8000_0000, 32'd1);
    chk("sub_ovf.result_const", alu_bus.result_o, 32'h7FFF_FFFF);
    issue_check("sub_3_3", ALU_SUB, 32'd3, 32'd3);
    chk("sub_3_3.zero_const", alu_bus.zero_o, 1'b1);

    issue_check("undef_0101", 4'b0101, 32'h0000_FFFF, 32'h0000_FFFF);
    chk("undef_0101.zero_const", alu_bus.zero_o, 1'b1);
    @(negedge clk);

    mul_check("mul_ff_3", 32'hFFFF_FFFF, 32'd3, 1'b1);
    chk("mul_ff_3.result_const", alu_bus.result_o, 32'hFFFF_FFFD);
    issue_check("b2b_after_mul", ALU_ADD, 32'd1, 32'd2);

    // Reset mid-MUL: outputs clear without a clock edge, no valid afterwards.
    alu_bus.src1_i  = 32'd1234;
    alu_bus.src2_i  = 32'd5678;
    alu_bus.ctrl_i  = ALU_MUL;
    alu_bus.start_i = 1'b1;
    @(negedge clk);
    alu_bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort.busy_before", alu_bus.busy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_outs("abort.async", '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (alu_bus.valid_o === 1'b1 || alu_bus.busy_o === 1'b1) pulses++;
    end
    chk("abort.no_valid", W'(pulses), '0);
    issue_check("add_1_1", ALU_ADD, 32'd1, 32'd1);
    chk("add_1_1.result_const", alu_bus.result_o, 32'd2);

    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 7)];
      ra = rand_operand();
      rb = rand_operand();
      if (op == ALU_MUL) mul_check("rnd_mul", ra, rb, ($urandom_range(0, 1) == 1));
      else issue_check("rnd_op", op, ra, rb);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        chk("rnd.valid_drop", alu_bus.valid_o, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU controller.
- Adds an iterative multiply (MUL) to the existing single-cycle ops, so the CPU can stall on a busy/valid handshake.
- Sits between the ALU controller/register-file read and the write-back mux.
- Single-cycle ops complete in 1 cycle; MUL takes WIDTH cycles.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  asynchronous, active-low reset
src1_i  input  WIDTH  operand A (rs)
src2_i  input  WIDTH  operand B (rt or sign-extended immediate)
ctrl_i  input  4  ALU control code from the ALU controller
start_i  input  1  issue request; accepted only when busy_o=0
result_o  output  WIDTH  registered result
zero_o  output  1  registered; 1 when result_o==0
overflow_o  output  1  registered; signed overflow for ADD/SUB, 0 otherwise
valid_o  output  1  one-cycle pulse; result_o/zero_o/overflow_o updated this cycle
busy_o  output  1  high while a MUL is iterating; start_i ignored

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE; result_o=0, zero_o=0, overflow_o=0, valid_o=0, busy_o=0; counter and MUL datapath cleared.
- Reset during a MUL aborts it; no valid_o is produced for the aborted op.
- ctrl_i codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed; result 1 or 0), 1100 NOR: single-cycle.
  - 1000 MUL: iterative.
  - Any other code: single-cycle, result 0.
- States: IDLE, MUL_RUN.
- IDLE:
  - start_i=1 with a single-cycle code in cycle 0: result_o, zero_o, overflow_o and valid_o=1 appear in cycle 1. State stays IDLE.
  - start_i=1 with MUL in cycle 0: latch src1_i/src2_i, clear accumulator, counter=0, go to MUL_RUN. busy_o=1 from cycle 1.
- MUL_RUN:
  - Shift-add one multiplier bit per cycle, LSB first. Accumulator is WIDTH bits; only the low WIDTH bits of the product are kept, so signed and unsigned results are identical.
  - counter increments each cycle. When counter reaches WIDTH-1, the final product is registered and the state returns to IDLE.
  - busy_o=1 for cycles 1..WIDTH. valid_o=1 and busy_o=0 in cycle WIDTH+1.
  - overflow_o=0 for MUL.
- start_i while busy_o=1 is ignored: no queueing and no effect on the in-flight op.
- start_i is accepted in the same cycle valid_o is high (back-to-back issue allowed).
- valid_o is high for exactly one cycle per accepted op. Outputs hold their last values between valid pulses.
- Operands and ctrl_i are sampled only at acceptance; later changes do not affect an in-flight MUL.
- Overflow rules:
  - ADD: overflow = sign(A)==sign(B) and sign(result)!=sign(A).
  - SUB: overflow = sign(A)!=sign(B) and sign(result)!=sign(A).
  - Results wrap modulo 2^WIDTH.
- SLT uses a true signed comparison, correct even when A-B overflows.

Decomposition:
- Shared package alu_pkg holds:
  - ALU control code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_MUL), so the ALU controller and this block share one encoding.
  - The state encoding (IDLE, MUL_RUN).
- One sub-module: shift_add_mul, the iterative multiplier datapath (operand latch, accumulator, counter, done flag). The top level holds the single-cycle ops, the FSM and the output registers.

Test Plan:
- ADD 7+5, start cycle 0 -> cycle 1: result_o=12, zero_o=0, overflow_o=0, valid_o=1; cycle 2: valid_o=0, result_o holds 12.
- SUB 5-7, then SLT 5,7 back-to-back -> result_o 0xFFFFFFFE, then 1; each with a one-cycle valid_o; SLT 0x80000000,1 -> result_o=1.
- ADD 0x7FFFFFFF+1 -> result_o 0x80000000, overflow_o=1; SUB 0x80000000-1 -> result_o 0x7FFFFFFF, overflow_o=1; SUB 3-3 -> zero_o=1.
- MUL 0xFFFFFFFF*3 -> busy_o high cycles 1..32; ADD start in cycle 10 ignored; cycle 33: result_o=0xFFFFFFFD, valid_o=1, busy_o=0; new start in cycle 33 accepted.
- MUL 1234*5678 with rst_i low in cycle 10 -> all outputs 0 immediately (no clock edge); no valid_o afterwards; next ADD 1+1 after release -> result_o=2.
- Undefined code 0101 with src1=src2=0xFFFF -> cycle 1: result_o=0, zero_o=1, overflow_o=0, valid_o=1.
